// File: rtl/fetch_unit.sv
// Instruction fetch: boots from the reset vector, streams sequential words over a
// req/ack bus into a small FIFO, and hands them to decode; redirect flushes everything.
module fetch_unit #(
  parameter int          DEPTH        = 4,
  parameter logic [15:0] RST_VEC_ADDR = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [15:0] MAB_out,
  input  logic [15:0] MDB_in,
  input  logic        mem_ack,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  output logic [15:0] ir_data,
  output logic [15:0] ir_addr,
  input  logic        ir_ready,
  output logic        boot_done
);
  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] addr;
  } ir_entry_t;

  typedef enum logic [1:0] {HOLD, BOOT, RUN, REDIR} state_t;

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [PW:0]   count, count_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  ir_entry_t     fifo [DEPTH];
  ir_entry_t     head, head_nxt, push_ent;
  logic          push, pop, flush;

  assign mem_rd   = (state == BOOT) || (state == RUN && count != FULL);
  assign MAB_out  = (state == RUN || state == REDIR) ? fetch_pc : RST_VEC_ADDR;
  assign ir_valid = (count != '0);
  assign ir_data  = head.data;
  assign ir_addr  = head.addr;

  assign flush    = redirect && (state == RUN || state == REDIR);
  assign push     = (state == RUN) && mem_rd && mem_ack && !redirect;
  assign pop      = ir_valid && ir_ready && !flush;
  assign push_ent = '{data: MDB_in, addr: fetch_pc};

  // Head register looks one edge ahead; a push into an empty (or draining-to-one)
  // FIFO lands directly in the head so push-to-valid latency is a single cycle.
  always_comb begin
    rd_nxt    = rd_ptr + PW'(pop);
    count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
    head_nxt  = head;
    if (count_nxt != '0)
      head_nxt = (push && wr_ptr == rd_nxt) ? push_ent : fifo[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HOLD;
      fetch_pc  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      head      <= '0;
      boot_done <= 1'b0;
    end else begin
      case (state)
        HOLD: state <= BOOT;
        BOOT: if (mem_ack) begin
          fetch_pc  <= {MDB_in[15:1], 1'b0};
          boot_done <= 1'b1;
          state     <= RUN;
        end
        RUN, REDIR: begin
          state <= RUN;
          if (redirect) begin
            fetch_pc <= redirect_pc & 16'hFFFE;
            state    <= REDIR;
          end else if (push) begin
            fetch_pc <= fetch_pc + 16'd2;
          end
        end
        default: state <= HOLD;
      endcase

      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count  <= count_nxt;
        rd_ptr <= rd_nxt;
        head   <= head_nxt;
        if (push) wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with programmable wait states and an
// expected-address stream model of sequential fetch.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd;
  logic [15:0] MAB_out;
  logic [15:0] MDB_in;
  logic        mem_ack;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        ir_valid;
  logic [15:0] ir_data, ir_addr;
  logic        ir_ready = 1'b0;
  logic        boot_done;

  int          tests = 0;
  int          fails = 0;
  int          waits = 0;
  logic [15:0] exp_pc;

  fetch_unit #(.DEPTH(DEPTH), .RST_VEC_ADDR(16'hFFFE)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .MAB_out(MAB_out), .MDB_in(MDB_in),
    .mem_ack(mem_ack), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_addr(ir_addr),
    .ir_ready(ir_ready), .boot_done(boot_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'hFFFE) ? 16'hC001 : (a ^ 16'hA5A5);
  endfunction

  // Memory: acks after `waits` idle request cycles, data valid only with ack.
  initial begin
    int wc;
    wc = 0; mem_ack = 1'b0; MDB_in = '0;
    forever begin
      @(negedge clk);
      if (rst && mem_rd) begin
        if (wc >= waits) begin
          mem_ack = 1'b1; MDB_in = mem_word(MAB_out); wc = 0;
        end else begin
          mem_ack = 1'b0; MDB_in = 16'hDEAD; wc++;
        end
      end else begin
        mem_ack = 1'b0; MDB_in = 16'hDEAD; wc = 0;
      end
    end
  end

  task automatic tick;
    @(negedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; ir_ready = 1'b0; redirect = 1'b0;
    repeat (3) tick;
    tests++;
    if (mem_rd !== 1'b0 || MAB_out !== 16'hFFFE) begin
      fails++; $display("FAIL reset_bus: mem_rd=%b MAB=%h, want 0 FFFE", mem_rd, MAB_out);
    end
    tests++;
    if (ir_valid !== 1'b0 || ir_data !== 16'h0 || ir_addr !== 16'h0) begin
      fails++; $display("FAIL reset_ir: valid=%b data=%h addr=%h, want 0 0000 0000", ir_valid, ir_data, ir_addr);
    end
    tests++;
    if (boot_done !== 1'b0) begin
      fails++; $display("FAIL reset_boot_done: got %b want 0", boot_done);
    end
  endtask

  task automatic test_boot;
    rst = 1'b1;
    tick;
    tests++;
    if (mem_rd !== 1'b1 || MAB_out !== 16'hFFFE || boot_done !== 1'b0) begin
      fails++; $display("FAIL boot_req: rd=%b MAB=%h bd=%b, want 1 FFFE 0", mem_rd, MAB_out, boot_done);
    end
    tick;
    tests++;
    if (boot_done !== 1'b1 || MAB_out !== 16'hC000 || mem_rd !== 1'b1) begin
      fails++; $display("FAIL boot_vec: bd=%b MAB=%h rd=%b, want 1 C000 1", boot_done, MAB_out, mem_rd);
    end
    tick;
    exp_pc = 16'hC000;
    tests++;
    if (ir_valid !== 1'b1 || ir_addr !== exp_pc || ir_data !== mem_word(exp_pc)) begin
      fails++; $display("FAIL boot_first: v=%b addr=%h data=%h, want 1 %h %h", ir_valid, ir_addr, ir_data, exp_pc, mem_word(exp_pc));
    end
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (ir_valid !== 1'b1 || ir_addr !== exp_pc || ir_data !== mem_word(exp_pc)) begin
        fails++; $display("FAIL stream[%0d]: v=%b addr=%h data=%h, want 1 %h %h", i, ir_valid, ir_addr, ir_data, exp_pc, mem_word(exp_pc));
      end
      ir_ready = 1'b1; exp_pc += 16'd2;
      tick;
    end
  endtask

  task automatic test_backpressure;
    int n;
    bit rdy;
    ir_ready = 1'b0;
    repeat (8) tick;
    tests++;
    if (ir_valid !== 1'b1 || ir_addr !== exp_pc || ir_data !== mem_word(exp_pc)) begin
      fails++; $display("FAIL bp_head: v=%b addr=%h, want 1 %h", ir_valid, ir_addr, exp_pc);
    end
    tests++;
    if (mem_rd !== 1'b0 || MAB_out !== exp_pc + 16'(2*DEPTH)) begin
      fails++; $display("FAIL bp_full: rd=%b MAB=%h, want 0 %h", mem_rd, MAB_out, exp_pc + 16'(2*DEPTH));
    end
    ir_ready = 1'b1; exp_pc += 16'd2;
    tick;
    ir_ready = 1'b0;
    tests++;
    if (mem_rd !== 1'b1) begin
      fails++; $display("FAIL bp_resume: rd=%b want 1", mem_rd);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (ir_valid) begin
        tests++;
        if (ir_addr !== exp_pc || ir_data !== mem_word(exp_pc)) begin
          fails++; $display("FAIL bp_order[%0d]: addr=%h data=%h, want %h %h", i, ir_addr, ir_data, exp_pc, mem_word(exp_pc));
        end
      end
      rdy = 1'($urandom_range(0, 1));
      ir_ready = rdy;
      if (ir_valid && rdy) begin exp_pc += 16'd2; n++; end
      tick;
    end
    tests++;
    if (n < 5) begin
      fails++; $display("FAIL bp_progress: delivered %0d, want >= 5", n);
    end
  endtask

  task automatic test_wait_states;
    int n;
    bit rdy, prev_rd, prev_ack;
    logic [15:0] prev_mab;
    waits = 2; n = 0; prev_rd = 0; prev_ack = 0; prev_mab = '0;
    for (int i = 0; i < 60; i++) begin
      if (prev_rd && !prev_ack) begin
        tests++;
        if (mem_rd !== 1'b1 || MAB_out !== prev_mab) begin
          fails++; $display("FAIL ws_hold[%0d]: rd=%b MAB=%h, want 1 %h", i, mem_rd, MAB_out, prev_mab);
        end
      end
      if (ir_valid) begin
        tests++;
        if (ir_addr !== exp_pc || ir_data !== mem_word(exp_pc)) begin
          fails++; $display("FAIL ws_order[%0d]: addr=%h data=%h, want %h %h", i, ir_addr, ir_data, exp_pc, mem_word(exp_pc));
        end
      end
      prev_rd = mem_rd; prev_ack = mem_ack; prev_mab = MAB_out;
      rdy = 1'($urandom_range(0, 1));
      ir_ready = rdy;
      if (ir_valid && rdy) begin exp_pc += 16'd2; n++; end
      tick;
    end
    tests++;
    if (n < 5) begin
      fails++; $display("FAIL ws_progress: delivered %0d, want >= 5", n);
    end
    waits = 0;
  endtask

  task automatic test_redirect;
    for (int i = 0; i < 6; i++) begin
      if (ir_valid) begin
        tests++;
        if (ir_addr !== exp_pc || ir_data !== mem_word(exp_pc)) begin
          fails++; $display("FAIL rd_pre[%0d]: addr=%h, want %h", i, ir_addr, exp_pc);
        end
        exp_pc += 16'd2;
      end
      ir_ready = 1'b1;
      tick;
    end
    tests++;
    if (ir_valid !== 1'b1 || mem_rd !== 1'b1 || mem_ack !== 1'b1) begin
      fails++; $display("FAIL rd_setup: v=%b rd=%b ack=%b, want 1 1 1", ir_valid, mem_rd, mem_ack);
    end
    redirect = 1'b1; redirect_pc = 16'h4123; ir_ready = 1'b1;
    tick;
    redirect = 1'b0;
    exp_pc = 16'h4122;
    tests++;
    if (ir_valid !== 1'b0 || mem_rd !== 1'b0 || MAB_out !== 16'h4122) begin
      fails++; $display("FAIL rd_gap: v=%b rd=%b MAB=%h, want 0 0 4122", ir_valid, mem_rd, MAB_out);
    end
    tick;
    tests++;
    if (ir_valid !== 1'b0 || mem_rd !== 1'b1 || MAB_out !== 16'h4122) begin
      fails++; $display("FAIL rd_refetch: v=%b rd=%b MAB=%h, want 0 1 4122", ir_valid, mem_rd, MAB_out);
    end
    tick;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (ir_valid !== 1'b1 || ir_addr !== exp_pc || ir_data !== mem_word(exp_pc)) begin
        fails++; $display("FAIL rd_stream[%0d]: v=%b addr=%h data=%h, want 1 %h %h", i, ir_valid, ir_addr, ir_data, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 16'd2;
      tick;
    end
  endtask

  task automatic test_wrap_reset;
    int n;
    bit found;
    ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFC;
    tick;
    redirect = 1'b0;
    exp_pc = 16'hFFFC;
    n = 0;
    for (int i = 0; i < 10 && n < 3; i++) begin
      if (ir_valid) begin
        tests++;
        if (ir_addr !== exp_pc || ir_data !== mem_word(exp_pc)) begin
          fails++; $display("FAIL wrap[%0d]: addr=%h data=%h, want %h %h", n, ir_addr, ir_data, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 16'd2; n++;
      end
      tick;
    end
    tests++;
    if (n != 3) begin
      fails++; $display("FAIL wrap_count: delivered %0d, want 3", n);
    end
    waits = 3; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick;
      found = mem_rd && !mem_ack;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL rst_wait_seen: no wait cycle within 20, want one");
    end
    rst = 1'b0;
    #1;
    tests++;
    if (mem_rd !== 1'b0 || ir_valid !== 1'b0) begin
      fails++; $display("FAIL rst_async: rd=%b v=%b, want 0 0", mem_rd, ir_valid);
    end
    tests++;
    if (boot_done !== 1'b0 || MAB_out !== 16'hFFFE) begin
      fails++; $display("FAIL rst_state: bd=%b MAB=%h, want 0 FFFE", boot_done, MAB_out);
    end
    tick; tick;
    waits = 0; rst = 1'b1;
    tick;
    tests++;
    if (mem_rd !== 1'b1 || MAB_out !== 16'hFFFE) begin
      fails++; $display("FAIL reboot_req: rd=%b MAB=%h, want 1 FFFE", mem_rd, MAB_out);
    end
    tick;
    tests++;
    if (boot_done !== 1'b1 || MAB_out !== 16'hC000) begin
      fails++; $display("FAIL reboot_vec: bd=%b MAB=%h, want 1 C000", boot_done, MAB_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_boot;
    test_streaming;
    test_backpressure;
    test_wait_states;
    test_redirect;
    test_wrap_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
